tile_fetch_streamer: RTL and testbench

// Fetches one TILE x TILE pixel tile from the dual-port image ROM (NPU port) and streams it
// row-major as a valid/ready pixel stream into the systolic-array input stage. Replaces the
// one-read-per-three-cycles fetch in the top-level FSM with a pipelined one-read-per-cycle fetch.
// A credit-limited skid FIFO absorbs in-flight ROM reads under backpressure, so no pixel is lost.

---
 rtl/tile_fetch_streamer.sv | 222 ++++++++++++++++++++++
 tb/tb_tile_fetch_streamer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tile_fetch_streamer.sv
// Tile fetch streamer: reads one TILE x TILE pixel tile from the image ROM at one read
// per cycle and streams it row-major as a valid/ready pixel stream. Reads are credit
// limited so the skid FIFO can always absorb every ROM read already in flight.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start; range-checks the tile and issues read 0
// S_FETCH  | issuing one read per cycle while FIFO credit allows
// S_DRAIN  | all reads issued; waiting for the last pixel handshake
// S_FINISH | done pulse; busy still high for this one cycle
module tile_fetch_streamer #(
  parameter int IMG_W   = 400,
  parameter int IMG_H   = 400,
  parameter int TILE    = 10,
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 2,
  parameter int FIFO_D  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [5:0]        i_tile_x,
  input  logic [5:0]        i_tile_y,
  output logic              o_busy,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [3:0]        o_out_row,
  output logic [3:0]        o_out_col,
  output logic              o_out_last,
  output logic              o_done
);

  localparam logic [5:0]        TILES_X    = 6'(IMG_W / TILE);
  localparam logic [5:0]        TILES_Y    = 6'(IMG_H / TILE);
  localparam logic [3:0]        LAST_IDX   = 4'(TILE - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(TILE * IMG_W);
  localparam logic [ADDR_W-1:0] TILE_STEP  = ADDR_W'(TILE);
  localparam logic [ADDR_W-1:0] WRAP_STEP  = ADDR_W'(IMG_W - (TILE - 1));
  localparam int                PTR_W      = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int                CNT_W      = $clog2(FIFO_D + 1);
  localparam int                SUM_W      = $clog2(FIFO_D + ROM_LAT + 2);
  localparam logic [PTR_W-1:0]  PTR_MAX    = PTR_W'(FIFO_D - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FINISH} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic [3:0]          r_iss_row;
  logic [3:0]          r_iss_col;
  logic                r_busy;
  logic                r_err;
  logic                r_done;

  logic [ROM_LAT-1:0]  r_pv;
  logic [3:0]          r_prow [ROM_LAT];
  logic [3:0]          r_pcol [ROM_LAT];

  logic [DATA_W-1:0]   r_fdata [FIFO_D];
  logic [3:0]          r_frow  [FIFO_D];
  logic [3:0]          r_fcol  [FIFO_D];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_fcnt;

  logic                w_range_ok;
  logic                w_start_issue;
  logic [ADDR_W-1:0]   w_base;
  logic [SUM_W-1:0]    w_inflight;
  logic                w_credit;
  logic                w_issue;
  logic                w_col_wrap;
  logic [3:0]          w_next_row;
  logic [3:0]          w_next_col;
  logic [ADDR_W-1:0]   w_next_addr;
  logic                w_next_last;
  logic                w_push;
  logic                w_pop;
  logic                w_valid;
  logic                w_head_last;

  assign w_range_ok    = (i_tile_x < TILES_X) && (i_tile_y < TILES_Y);
  assign w_start_issue = (r_state == S_IDLE) && i_start && w_range_ok;
  assign w_base        = ADDR_W'(i_tile_y) * ROW_STRIDE + ADDR_W'(i_tile_x) * TILE_STEP;

  // Count of reads issued whose data has not yet landed in the FIFO.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      w_inflight = w_inflight + SUM_W'(r_pv[i]);
    end
  end

  // Credit uses the current count only (ignores a same-cycle pop), which still sustains
  // one read per cycle once the stream is flowing.
  assign w_credit    = (SUM_W'(r_fcnt) + w_inflight + SUM_W'(1)) <= SUM_W'(FIFO_D);
  assign w_issue     = (r_state == S_FETCH) && w_credit;
  assign w_col_wrap  = (r_iss_col == LAST_IDX);
  assign w_next_col  = w_col_wrap ? 4'd0 : r_iss_col + 4'd1;
  assign w_next_row  = w_col_wrap ? r_iss_row + 4'd1 : r_iss_row;
  assign w_next_addr = w_col_wrap ? r_rom_addr + WRAP_STEP : r_rom_addr + ADDR_W'(1);
  assign w_next_last = (w_next_row == LAST_IDX) && (w_next_col == LAST_IDX);

  assign w_push      = r_pv[ROM_LAT-1];
  assign w_valid     = (r_fcnt != '0);
  assign w_pop       = w_valid && i_out_ready;
  assign w_head_last = w_valid && (r_frow[r_rptr] == LAST_IDX) && (r_fcol[r_rptr] == LAST_IDX);

  // Sequencing FSM: owns the ROM address, issue position and the status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_rom_addr <= '0;
      r_iss_row  <= '0;
      r_iss_col  <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_err  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_range_ok) begin
              r_rom_addr <= w_base;
              r_iss_row  <= 4'd0;
              r_iss_col  <= 4'd0;
              r_busy     <= 1'b1;
              r_state    <= S_FETCH;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            r_rom_addr <= w_next_addr;
            r_iss_row  <= w_next_row;
            r_iss_col  <= w_next_col;
            if (w_next_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && w_head_last) begin
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // In-flight tracker: row/col tags travel alongside the ROM latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pv <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        r_prow[i] <= '0;
        r_pcol[i] <= '0;
      end
    end else begin
      r_pv[0]   <= w_start_issue || w_issue;
      r_prow[0] <= w_start_issue ? 4'd0 : w_next_row;
      r_pcol[0] <= w_start_issue ? 4'd0 : w_next_col;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_prow[i] <= r_prow[i-1];
        r_pcol[i] <= r_pcol[i-1];
      end
    end
  end

  // Skid FIFO: captures ROM data with its tags, head drives the output stream.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
      for (int i = 0; i < FIFO_D; i++) begin
        r_fdata[i] <= '0;
        r_frow[i]  <= '0;
        r_fcol[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_fdata[r_wptr] <= i_rom_data;
        r_frow[r_wptr]  <= r_prow[ROM_LAT-1];
        r_fcol[r_wptr]  <= r_pcol[ROM_LAT-1];
        r_wptr          <= (r_wptr == PTR_MAX) ? '0 : r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_MAX) ? '0 : r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + CNT_W'(1);
        2'b01:   r_fcnt <= r_fcnt - CNT_W'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_err       = r_err;
  assign o_done      = r_done;
  assign o_rom_addr  = r_rom_addr;
  assign o_out_valid = w_valid;
  assign o_out_data  = r_fdata[r_rptr];
  assign o_out_row   = r_frow[r_rptr];
  assign o_out_col   = r_fcol[r_rptr];
  assign o_out_last  = w_head_last;

endmodule

// File: tb/tb_tile_fetch_streamer.sv
// Directed bench for tile_fetch_streamer with a 2-cycle ROM model (q = addr[7:0]).
module tb_tile_fetch_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  tx, ty;
  logic        busy, err, done;
  logic [17:0] rom_addr;
  logic [7:0]  rom_q;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_data;
  logic [3:0]  out_row, out_col;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  // ROM: internal address register, so q belongs to the address registered two edges back
  always @(posedge clk) rom_q <= rom_addr[7:0];

  tile_fetch_streamer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_tile_x(tx), .i_tile_y(ty),
    .o_busy(busy), .o_err(err), .o_rom_addr(rom_addr), .i_rom_data(rom_q),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_row(out_row), .o_out_col(out_col), .o_out_last(out_last), .o_done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_err"},   32'(err), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_last"},  32'(out_last), 0);
    chk({tag, "_addr"},  32'(rom_addr), 0);
    chk({tag, "_data"},  32'(out_data), 0);
    chk({tag, "_row"},   32'(out_row), 0);
    chk({tag, "_col"},   32'(out_col), 0);
  endtask

  // mode 0: ready high; 1: random ready; 2: ready low for 'stall' cycles then high
  task automatic run_stream(input int tid, input int stx, input int sty, input int mode,
                            input int stall, input int restart_at, input int abort_beat,
                            output int first_cyc, output int done_cyc, output int nbeats);
    int base, k, cyc, off, issued, ahead_bad, stable_bad, busy_bad, gaps, r, c, ea;
    bit aborted, prev_stall;
    logic [7:0] prev_data;
    logic [3:0] prev_row, prev_col;
    base = sty * 4000 + stx * 10;
    first_cyc = -1; done_cyc = -1; k = 0; cyc = 0;
    ahead_bad = 0; stable_bad = 0; busy_bad = 0; gaps = 0;
    aborted = 0; prev_stall = 0;
    prev_data = '0; prev_row = '0; prev_col = '0;
    @(negedge clk);
    start = 1'b1; tx = 6'(stx); ty = 6'(sty); out_ready = (mode == 0);
    while (done_cyc < 0 && !aborted && cyc < 600) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == restart_at) begin start = 1'b1; tx = 6'd5; ty = 6'd5; end
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else                out_ready = (cyc > stall);
      if (cyc == 1) chk($sformatf("t%0d_first_addr", tid), 32'(rom_addr), base);
      if (mode == 2 && (cyc == 10 || cyc == stall))
        chk($sformatf("t%0d_stall_addr_c%0d", tid, cyc), 32'(rom_addr), base + 3);
      if (prev_stall && (!out_valid || out_data !== prev_data ||
                         out_row !== prev_row || out_col !== prev_col)) stable_bad++;
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (first_cyc > 0 && !out_valid && k < 100) gaps++;
      off = int'(rom_addr) - base;
      issued = (off / 400) * 10 + (off % 400) + 1;
      if (issued - k > 4) ahead_bad++;
      if (!busy) busy_bad++;
      if (done) done_cyc = cyc;
      if (abort_beat >= 0 && k == abort_beat && out_valid) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outputs($sformatf("t%0d_abort", tid));
        aborted = 1;
      end else if (out_valid && out_ready) begin
        r = k / 10; c = k % 10; ea = base + r * 400 + c;
        chk($sformatf("t%0d_data_b%0d", tid, k), 32'(out_data), ea & 255);
        chk($sformatf("t%0d_row_b%0d", tid, k),  32'(out_row), r);
        chk($sformatf("t%0d_col_b%0d", tid, k),  32'(out_col), c);
        chk($sformatf("t%0d_last_b%0d", tid, k), 32'(out_last), (k == 99) ? 1 : 0);
        k++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data; prev_row = out_row; prev_col = out_col;
    end
    nbeats = k;
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      chk($sformatf("t%0d_timeout", tid), 32'(done_cyc > 0), 1);
      chk($sformatf("t%0d_beats", tid), k, 100);
      chk($sformatf("t%0d_busy_low", tid), busy_bad, 0);
      chk($sformatf("t%0d_unstable", tid), stable_bad, 0);
      chk($sformatf("t%0d_ahead", tid), ahead_bad, 0);
      if (mode != 1) chk($sformatf("t%0d_gaps", tid), gaps, 0);
      chk($sformatf("t%0d_last_addr", tid), 32'(rom_addr), base + 9 * 400 + 9);
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        chk($sformatf("t%0d_post_busy%0d", tid, i), 32'(busy), 0);
        chk($sformatf("t%0d_post_done%0d", tid, i), 32'(done), 0);
        chk($sformatf("t%0d_post_valid%0d", tid, i), 32'(out_valid), 0);
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int f, d, n;
    logic [17:0] addr_before;
    rst_n = 1'b0; start = 1'b0; tx = '0; ty = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // tile (0,0), full rate
    run_stream(1, 0, 0, 0, 0, -1, -1, f, d, n);
    chk("t1_first_valid_cyc", f, 3);
    chk("t1_done_cyc", d, 103);

    // bottom-right tile: address range 156390..159999
    run_stream(2, 39, 39, 0, 0, -1, -1, f, d, n);
    chk("t2_done_cyc", d, 103);

    // random backpressure
    run_stream(3, 3, 7, 1, 0, -1, -1, f, d, n);
    chk("t3_first_valid_cyc", f, 3);

    // ready low for 20 cycles: four reads, address held, then clean resume
    run_stream(4, 1, 2, 2, 20, -1, -1, f, d, n);
    chk("t4_done_cyc", d, 121);

    // out-of-range tile_x
    @(negedge clk);
    addr_before = rom_addr;
    start = 1'b1; tx = 6'd40; ty = 6'd0;
    @(negedge clk);
    start = 1'b0;
    chk("t5_err_pulse", 32'(err), 1);
    chk("t5_err_busy", 32'(busy), 0);
    chk("t5_err_addr", 32'(rom_addr), 32'(addr_before));
    @(negedge clk);
    chk("t5_err_clear", 32'(err), 0);
    chk("t5_err_busy2", 32'(busy), 0);
    chk("t5_err_addr2", 32'(rom_addr), 32'(addr_before));

    // start during busy must be ignored
    run_stream(6, 2, 2, 0, 0, 10, -1, f, d, n);
    chk("t6_done_cyc", d, 103);

    // reset at beat 50, then a fresh full tile
    run_stream(7, 4, 4, 0, 0, -1, 50, f, d, n);
    chk("t7_abort_beats", n, 50);
    run_stream(8, 4, 4, 0, 0, -1, -1, f, d, n);
    chk("t8_first_valid_cyc", f, 3);
    chk("t8_done_cyc", d, 103);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
